npc_exec_seq: RTL and testbench
===============================

// Module: npc_exec_seq
// PURPOSE
//  Multi-cycle sequencer for the NPC core. Drives the combinational control unit/ALU datapath through
//  FETCH -> EXEC -> MEM -> WB. Issues valid/ready requests to the instruction port (IFU) and data port (LSU),
//  holds inst/pc/load data stable for the CU, and gates the regfile write and PC update to one commit cycle.
// PARAMETERS
//  RESET_PC   32'h8000_0000  PC loaded on reset
//  NOP_INST   32'h0000_0013  inst value held after reset (addi x0,x0,0)
// PORTS
//  clk             in   1   core clock, all state on posedge
//  rst_n           in   1   asynchronous, active-low reset
//  ifu_req_valid   out  1   fetch request valid
//  ifu_req_addr    out  32  fetch address (= pc)
//  ifu_req_ready   in   1   IFU accepts request
//  ifu_rsp_valid   in   1   fetched instruction valid
//  ifu_rsp_data    in   32  fetched instruction
//  inst            out  32  latched instruction to decoder/CU
//  pc              out  32  architectural PC to CU
//  cu_pc_next      in   32  next PC from CU
//  cu_wen          in   1   CU regfile write request
//  cu_mem_rd       in   1   CU: load
//  cu_mem_wr       in   1   CU: store
//  cu_mem_addr     in   32  CU effective address
//  cu_mem_wdata    in   32  CU store data
//  cu_wmask        in   8   CU store byte mask
//  cu_is_ebreak    in   1   CU: ebreak
//  lsu_req_valid   out  1   data request valid
//  lsu_req_wen     out  1   1=store, 0=load
//  lsu_req_addr    out  32  data address
//  lsu_req_wdata   out  32  store data
//  lsu_req_wmask   out  8   store mask (0 for loads)
//  lsu_req_ready   in   1   LSU accepts request
//  lsu_rsp_valid   in   1   load data / store ack valid
//  lsu_rsp_rdata   in   32  load data
//  mem_read_data   out  32  latched load data to CU
//  rf_wen          out  1   gated regfile write enable
//  commit          out  1   one-cycle pulse per retired instruction
//  halted          out  1   core stopped on ebreak
//  perf_cycle      out  64  cycle counter (see CONFIGURATION)
//  perf_instret    out  64  retired-instruction counter
// BEHAVIOUR
//  Reset (async, any state): state=IF_REQ, pc=RESET_PC, inst=NOP_INST, mem_read_data=0, LSU request regs=0;
//   all valid/wen/commit/halted outputs 0 (Moore, decoded from state).
//  IF_REQ: ifu_req_valid=1, addr=pc held until ifu_req_ready -> IF_WAIT. rsp_valid here is ignored.
//  IF_WAIT: on ifu_rsp_valid latch inst -> EXEC.
//  EXEC (1 cycle, CU settles on latched inst): cu_is_ebreak -> HALT (commit=1 this cycle);
//   else cu_mem_rd|cu_mem_wr -> MEM_REQ, capturing addr/wdata/wmask/wen into LSU regs; else -> WB.
//  MEM_REQ: lsu_req_valid=1, payload stable until lsu_req_ready -> MEM_WAIT.
//  MEM_WAIT: on lsu_rsp_valid: loads latch rdata into mem_read_data; stores use it as ack -> WB.
//  WB (1 cycle): rf_wen=cu_wen, commit=1, pc<=cu_pc_next (verbatim, no alignment fixup) -> IF_REQ.
//  HALT: terminal; halted=1; no requests issued; only rst_n leaves.
//  Responses arriving in any state not waiting for them are dropped. Reset mid-transaction abandons it.
//  Latency with zero-wait ports (ready and rsp in same cycle as request): ALU/branch 4 cycles, load/store 6.
// CONFIGURATION
//  NPC_SEQ_PERF_EN defined: perf_cycle +1 every cycle out of reset (wraps at 2^64, stops in HALT);
//   perf_instret +1 on each commit; both reset to 0.
//  Not defined: counters not built; perf_cycle and perf_instret tied to 0.
// STRUCTURE
//  npc_seq_pkg: state encoding localparams (IF_REQ, IF_WAIT, EXEC, MEM_REQ, MEM_WAIT, WB, HALT),
//   NOP_INST, RESET_PC defaults.
//  Sub-module npc_perf_cnt (two 64-bit counters, inc_cycle/inc_instret inputs), instantiated only under the macro.
// TESTING
//  Zero-wait ports, inst 32'h00500093 (addi) -> commit at cycle 4, rf_wen=1 with commit, pc 8000_0000->8000_0004.
//  ifu_req_ready low 3 cycles -> valid/addr held constant, inst latched only on rsp_valid, no early commit.
//  Store sw, cu_wmask=8'hff, addr 8000_1000 -> one lsu request wen=1, rf_wen=0 at WB, commit 6 cycles after fetch.
//  Load, lsu_rsp_rdata=32'hDEADBEEF after 2 wait cycles -> mem_read_data=DEADBEEF during WB, rf_wen=1.
//  Branch cu_pc_next=8000_0040 -> next ifu_req_addr=8000_0040; ebreak -> halted=1, no further requests.
//  rst_n low in MEM_WAIT -> outputs zero immediately; after release fetch from RESET_PC; stale lsu_rsp ignored.

Source files
------------

// File: rtl/npc_seq_pkg.sv
// Shared definitions for the NPC multi-cycle sequencer: state encoding,
// reset defaults and the captured LSU request record.
package npc_seq_pkg;

    // Sequencer states
    localparam logic [2:0] IF_REQ   = 3'd0;
    localparam logic [2:0] IF_WAIT  = 3'd1;
    localparam logic [2:0] EXEC     = 3'd2;
    localparam logic [2:0] MEM_REQ  = 3'd3;
    localparam logic [2:0] MEM_WAIT = 3'd4;
    localparam logic [2:0] WB       = 3'd5;
    localparam logic [2:0] HALT     = 3'd6;

    // Reset defaults: boot address and addi x0,x0,0
    localparam logic [31:0] NPC_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NPC_NOP_INST = 32'h0000_0013;

    // Data-port request captured in EXEC and held through MEM_REQ
    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  wmask;
    } lsu_req_t;

endpackage

// File: rtl/npc_perf_cnt.sv
// Pair of free-running 64-bit performance counters (cycles and retired
// instructions). Only instantiated when NPC_SEQ_PERF_EN is defined.
module npc_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_cycle,
    input  logic        inc_instret,
    output logic [63:0] cycle,
    output logic [63:0] instret
);

    logic [63:0] r_cycle;
    logic [63:0] r_instret;

    // Count enabled cycles and retirements; both wrap naturally at 2^64
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle   <= '0;
            r_instret <= '0;
        end else begin
            if (inc_cycle)   r_cycle   <= r_cycle + 64'd1;
            if (inc_instret) r_instret <= r_instret + 64'd1;
        end
    end

    assign cycle   = r_cycle;
    assign instret = r_instret;

endmodule

// File: rtl/npc_exec_seq.sv
// NPC multi-cycle sequencer: FETCH -> EXEC -> MEM -> WB around a
// combinational CU/ALU. Holds inst/pc/load data stable for the CU and
// gates regfile write and PC update to the single commit cycle.
// Optional feature macro: NPC_SEQ_PERF_EN builds the cycle/instret counters;
// when undefined both counter outputs are tied to zero.
module npc_exec_seq
    import npc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = NPC_RESET_PC,
    parameter logic [31:0] NOP_INST = NPC_NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ifu_req_valid,
    output logic [31:0] ifu_req_addr,
    input  logic        ifu_req_ready,
    input  logic        ifu_rsp_valid,
    input  logic [31:0] ifu_rsp_data,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic [31:0] cu_pc_next,
    input  logic        cu_wen,
    input  logic        cu_mem_rd,
    input  logic        cu_mem_wr,
    input  logic [31:0] cu_mem_addr,
    input  logic [31:0] cu_mem_wdata,
    input  logic [7:0]  cu_wmask,
    input  logic        cu_is_ebreak,
    output logic        lsu_req_valid,
    output logic        lsu_req_wen,
    output logic [31:0] lsu_req_addr,
    output logic [31:0] lsu_req_wdata,
    output logic [7:0]  lsu_req_wmask,
    input  logic        lsu_req_ready,
    input  logic        lsu_rsp_valid,
    input  logic [31:0] lsu_rsp_rdata,
    output logic [31:0] mem_read_data,
    output logic        rf_wen,
    output logic        commit,
    output logic        halted,
    output logic [63:0] perf_cycle,
    output logic [63:0] perf_instret
);

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_mem_rdata;
    lsu_req_t    r_lsu;
    logic        w_commit;
    logic        w_mem_op;

    assign w_mem_op = cu_mem_rd | cu_mem_wr;

    // Next-state decode; responses outside their wait state are ignored
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IF_REQ:   if (ifu_req_ready) w_state_nxt = IF_WAIT;
            IF_WAIT:  if (ifu_rsp_valid) w_state_nxt = EXEC;
            EXEC: begin
                if (cu_is_ebreak)  w_state_nxt = HALT;
                else if (w_mem_op) w_state_nxt = MEM_REQ;
                else               w_state_nxt = WB;
            end
            MEM_REQ:  if (lsu_req_ready) w_state_nxt = MEM_WAIT;
            MEM_WAIT: if (lsu_rsp_valid) w_state_nxt = WB;
            WB:       w_state_nxt = IF_REQ;
            HALT:     w_state_nxt = HALT;
            default:  w_state_nxt = IF_REQ;
        endcase
    end

    // State register; reset abandons any in-flight transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IF_REQ;
        else        r_state <= w_state_nxt;
    end

    // Architectural/holding registers updated only in their owning state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_inst      <= NOP_INST;
            r_mem_rdata <= '0;
            r_lsu       <= '0;
        end else begin
            if (r_state == IF_WAIT && ifu_rsp_valid)
                r_inst <= ifu_rsp_data;
            if (r_state == EXEC && !cu_is_ebreak && w_mem_op)
                r_lsu <= '{wen:   cu_mem_wr,
                           addr:  cu_mem_addr,
                           wdata: cu_mem_wdata,
                           wmask: cu_mem_wr ? cu_wmask : 8'h00};
            if (r_state == MEM_WAIT && lsu_rsp_valid && !r_lsu.wen)
                r_mem_rdata <= lsu_rsp_rdata;
            if (r_state == WB)
                r_pc <= cu_pc_next;
        end
    end

    // ebreak retires in EXEC; everything else retires in WB
    assign w_commit = (r_state == WB) | ((r_state == EXEC) & cu_is_ebreak);

    // Reset state is IF_REQ, so the fetch valid is masked while rst_n is low
    assign ifu_req_valid = rst_n & (r_state == IF_REQ);
    assign ifu_req_addr  = r_pc;
    assign inst          = r_inst;
    assign pc            = r_pc;
    assign lsu_req_valid = (r_state == MEM_REQ);
    assign lsu_req_wen   = (r_state == MEM_REQ) & r_lsu.wen;
    assign lsu_req_addr  = r_lsu.addr;
    assign lsu_req_wdata = r_lsu.wdata;
    assign lsu_req_wmask = r_lsu.wmask;
    assign mem_read_data = r_mem_rdata;
    assign rf_wen        = (r_state == WB) & cu_wen;
    assign commit        = w_commit;
    assign halted        = (r_state == HALT);

`ifdef NPC_SEQ_PERF_EN
    logic w_inc_cycle;
    assign w_inc_cycle = (r_state != HALT);

    npc_perf_cnt u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc_cycle   (w_inc_cycle),
        .inc_instret (w_commit),
        .cycle       (perf_cycle),
        .instret     (perf_instret)
    );
`else
    assign perf_cycle   = '0;
    assign perf_instret = '0;
`endif

endmodule

// File: tb/tb_npc_exec_seq.sv
// Self-checking bench for npc_exec_seq: table of instruction vectors run
// through a reactive IFU/LSU model, expected commits kept in a scoreboard
// queue, plus hand-written reset-in-MEM_WAIT and ebreak/halt sequences.
module tb_npc_exec_seq;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid;
    logic [31:0] ifu_req_addr;
    logic        ifu_req_ready;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_data;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] cu_pc_next;
    logic        cu_wen;
    logic        cu_mem_rd;
    logic        cu_mem_wr;
    logic [31:0] cu_mem_addr;
    logic [31:0] cu_mem_wdata;
    logic [7:0]  cu_wmask;
    logic        cu_is_ebreak;
    logic        lsu_req_valid;
    logic        lsu_req_wen;
    logic [31:0] lsu_req_addr;
    logic [31:0] lsu_req_wdata;
    logic [7:0]  lsu_req_wmask;
    logic        lsu_req_ready;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rsp_rdata;
    logic [31:0] mem_read_data;
    logic        rf_wen;
    logic        commit;
    logic        halted;
    logic [63:0] perf_cycle;
    logic [63:0] perf_instret;

    npc_exec_seq dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_addr(ifu_req_addr),
        .ifu_req_ready(ifu_req_ready), .ifu_rsp_valid(ifu_rsp_valid),
        .ifu_rsp_data(ifu_rsp_data), .inst(inst), .pc(pc),
        .cu_pc_next(cu_pc_next), .cu_wen(cu_wen), .cu_mem_rd(cu_mem_rd),
        .cu_mem_wr(cu_mem_wr), .cu_mem_addr(cu_mem_addr),
        .cu_mem_wdata(cu_mem_wdata), .cu_wmask(cu_wmask),
        .cu_is_ebreak(cu_is_ebreak), .lsu_req_valid(lsu_req_valid),
        .lsu_req_wen(lsu_req_wen), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_req_ready(lsu_req_ready), .lsu_rsp_valid(lsu_rsp_valid),
        .lsu_rsp_rdata(lsu_rsp_rdata), .mem_read_data(mem_read_data),
        .rf_wen(rf_wen), .commit(commit), .halted(halted),
        .perf_cycle(perf_cycle), .perf_instret(perf_instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        bit          rd, wr, ebrk, wen, junk;
        logic [31:0] addr, wdata, rdata, pc_next;
        logic [7:0]  wmask;
        int          ifrw, ifsw, lsrw, lssw, lat;
    } vec_t;

    typedef struct {
        logic [31:0] pc, inst, mrd;
        logic        wen;
        int          lat;
    } exp_t;

    vec_t        vecs[8];
    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_mrd;
    logic [63:0] cyc_snap;

    function automatic vec_t mk(logic [31:0] i, bit rd, bit wr, bit eb, bit wen,
                                bit junk, logic [31:0] a, logic [31:0] wd,
                                logic [7:0] wm, logic [31:0] rdat, logic [31:0] pn,
                                int ifrw, int ifsw, int lsrw, int lssw, int lat);
        vec_t v;
        v.inst = i; v.rd = rd; v.wr = wr; v.ebrk = eb; v.wen = wen; v.junk = junk;
        v.addr = a; v.wdata = wd; v.wmask = wm; v.rdata = rdat; v.pc_next = pn;
        v.ifrw = ifrw; v.ifsw = ifsw; v.lsrw = lsrw; v.lssw = lssw; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic clr_inputs();
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; ifu_rsp_data = 32'h0;
        lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0; lsu_rsp_rdata = 32'h0;
    endtask

    // Run one instruction through a reactive IFU/LSU; commit checked via scoreboard
    task automatic run_vec(input vec_t v);
        int   n = 0, ifr = 0, ifs = 0, lr = 0, ls = 0, n_ls = 0;
        bit   acc_if = 0, got_if = 0, acc_ls = 0, got_ls = 0, done = 0;
        exp_t e;
        cu_pc_next = v.pc_next; cu_wen = v.wen; cu_mem_rd = v.rd; cu_mem_wr = v.wr;
        cu_mem_addr = v.addr; cu_mem_wdata = v.wdata; cu_wmask = v.wmask;
        cu_is_ebreak = v.ebrk;
        if (v.rd) exp_mrd = v.rdata;
        e.pc = exp_pc; e.inst = v.inst; e.mrd = exp_mrd;
        e.wen = v.wen & ~v.ebrk; e.lat = v.lat;
        sb_q.push_back(e);
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
            clr_inputs();
            if (commit) begin
                done = 1;
                if (sb_q.size() == 0) begin
                    n_err++; n_cmp++;
                    $display("FAIL commit_unexpected: got commit want none");
                end else begin
                    e = sb_q.pop_front();
                    chk("commit_cycle", 64'(n), 64'(e.lat));
                    chk("commit_rf_wen", {63'd0, rf_wen}, {63'd0, e.wen});
                    chk("commit_inst", {32'd0, inst}, {32'd0, e.inst});
                    chk("commit_pc", {32'd0, pc}, {32'd0, e.pc});
                    chk("commit_mrd", {32'd0, mem_read_data}, {32'd0, e.mrd});
                    chk("lsu_req_count", 64'(n_ls), 64'(v.rd | v.wr));
                end
            end else begin
                if (ifu_req_valid) begin
                    chk("ifu_req_addr", {32'd0, ifu_req_addr}, {32'd0, exp_pc});
                    if (v.junk) begin
                        ifu_rsp_valid = 1'b1; ifu_rsp_data = 32'hFFFF_FFFF;
                        lsu_rsp_valid = 1'b1; lsu_rsp_rdata = 32'h5151_5151;
                    end
                    if (ifr < v.ifrw) ifr++;
                    else begin ifu_req_ready = 1'b1; acc_if = 1; end
                end else if (acc_if && !got_if) begin
                    if (ifs < v.ifsw) ifs++;
                    else begin ifu_rsp_valid = 1'b1; ifu_rsp_data = v.inst; got_if = 1; end
                end
                if (lsu_req_valid) begin
                    chk("lsu_wen", {63'd0, lsu_req_wen}, {63'd0, v.wr});
                    chk("lsu_addr", {32'd0, lsu_req_addr}, {32'd0, v.addr});
                    chk("lsu_wdata", {32'd0, lsu_req_wdata}, {32'd0, v.wdata});
                    chk("lsu_wmask", {56'd0, lsu_req_wmask}, {56'd0, (v.wr ? v.wmask : 8'h00)});
                    if (lr < v.lsrw) lr++;
                    else begin lsu_req_ready = 1'b1; acc_ls = 1; n_ls++; end
                end else if (acc_ls && !got_ls) begin
                    if (ls < v.lssw) ls++;
                    else begin lsu_rsp_valid = 1'b1; lsu_rsp_rdata = v.rdata; got_ls = 1; end
                end
            end
        end
        if (!done) begin
            n_err++; n_cmp++;
            $display("FAIL commit_timeout: got no commit in %0d cycles want %0d", n, v.lat);
            void'(sb_q.pop_front());
        end else if (!v.ebrk) begin
            @(posedge clk); #1;
            chk("pc_update", {32'd0, pc}, {32'd0, v.pc_next});
        end
        exp_pc = v.pc_next;
    endtask

    initial begin
        //              inst          rd wr eb wen junk addr          wdata         wmask  rdata         pc_next       ifrw ifsw lsrw lssw lat
        vecs[0] = mk(32'h0050_0093, 0, 0, 0, 1, 0, 32'h0,         32'h0,         8'h00, 32'h0,         32'h8000_0004, 0, 0, 0, 0, 4);
        vecs[1] = mk(32'h0010_0113, 0, 0, 0, 1, 1, 32'h0,         32'h0,         8'h00, 32'h0,         32'h8000_0008, 3, 0, 0, 0, 7);
        vecs[2] = mk(32'h0020_a023, 0, 1, 0, 0, 0, 32'h8000_1000, 32'h1234_5678, 8'hff, 32'h0,         32'h8000_000c, 0, 0, 0, 0, 6);
        vecs[3] = mk(32'h0000_a183, 1, 0, 0, 1, 0, 32'h8000_1000, 32'hAAAA_5555, 8'h0f, 32'hDEAD_BEEF, 32'h8000_0010, 0, 0, 0, 2, 8);
        vecs[4] = mk(32'h0210_8863, 0, 0, 0, 0, 0, 32'h0,         32'h0,         8'h00, 32'h0,         32'h8000_0040, 0, 0, 0, 0, 4);
        vecs[5] = mk(32'h0040_a203, 1, 0, 0, 1, 0, 32'h8000_2004, 32'h0,         8'h00, 32'hCAFE_F00D, 32'h8000_0044, 0, 1, 2, 0, 9);
        vecs[6] = mk(32'h0010_0093, 0, 0, 0, 1, 0, 32'h0,         32'h0,         8'h00, 32'h0,         32'h8000_0046, 0, 0, 0, 0, 4);
        vecs[7] = mk(32'h0020_0093, 0, 0, 0, 1, 0, 32'h0,         32'h0,         8'h00, 32'h0,         32'h8000_004a, 0, 0, 0, 0, 4);

        clr_inputs();
        cu_pc_next = 32'h0; cu_wen = 1'b0; cu_mem_rd = 1'b0; cu_mem_wr = 1'b0;
        cu_mem_addr = 32'h0; cu_mem_wdata = 32'h0; cu_wmask = 8'h0; cu_is_ebreak = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ifu_valid", {63'd0, ifu_req_valid}, 64'd0);
        chk("rst_lsu_valid", {63'd0, lsu_req_valid}, 64'd0);
        chk("rst_commit", {63'd0, commit}, 64'd0);
        chk("rst_halted", {63'd0, halted}, 64'd0);
        chk("rst_pc", {32'd0, pc}, {32'd0, RST_PC});
        chk("rst_inst", {32'd0, inst}, {32'd0, NOP});
        chk("rst_mrd", {32'd0, mem_read_data}, 64'd0);
        chk("rst_perf_cycle", perf_cycle, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_pc = RST_PC; exp_mrd = 32'h0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset while waiting for a load response
        cu_pc_next = 32'h8000_0050; cu_wen = 1'b1; cu_mem_rd = 1'b1; cu_mem_wr = 1'b0;
        cu_mem_addr = 32'h8000_2000; cu_wmask = 8'h00; cu_is_ebreak = 1'b0;
        @(negedge clk); clr_inputs(); ifu_req_ready = 1'b1;
        @(negedge clk); clr_inputs(); ifu_rsp_valid = 1'b1; ifu_rsp_data = 32'h0000_a183;
        @(negedge clk); clr_inputs();
        @(negedge clk); clr_inputs();
        chk("mr_lsu_valid", {63'd0, lsu_req_valid}, 64'd1);
        lsu_req_ready = 1'b1;
        @(negedge clk); clr_inputs();
        chk("mr_in_wait", {63'd0, lsu_req_valid | commit}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk("mr_ifu_valid", {63'd0, ifu_req_valid}, 64'd0);
        chk("mr_lsu_valid0", {63'd0, lsu_req_valid}, 64'd0);
        chk("mr_lsu_addr", {32'd0, lsu_req_addr}, 64'd0);
        chk("mr_commit", {63'd0, commit | rf_wen}, 64'd0);
        chk("mr_pc", {32'd0, pc}, {32'd0, RST_PC});
        chk("mr_inst", {32'd0, inst}, {32'd0, NOP});
        lsu_rsp_valid = 1'b1; lsu_rsp_rdata = 32'h0BAD_F00D;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("mr_refetch_valid", {63'd0, ifu_req_valid}, 64'd1);
        chk("mr_refetch_addr", {32'd0, ifu_req_addr}, {32'd0, RST_PC});
        chk("mr_stale_rsp", {32'd0, mem_read_data}, 64'd0);
        clr_inputs();
        exp_pc = RST_PC; exp_mrd = 32'h0;
        run_vec(mk(32'h0050_0093, 0, 0, 0, 1, 0, 32'h0, 32'h0, 8'h00, 32'h0, 32'h8000_0004, 0, 0, 0, 0, 4));

        // ebreak: retires in EXEC, then nothing further is requested
        run_vec(mk(32'h0010_0073, 0, 0, 1, 1, 0, 32'h0, 32'h0, 8'h00, 32'h0, 32'h8000_0008, 0, 0, 0, 0, 3));
        @(negedge clk);
        cyc_snap = perf_cycle;
        for (int k = 0; k < 5; k++) begin
            clr_inputs(); ifu_req_ready = 1'b1; ifu_rsp_valid = 1'b1;
            @(negedge clk);
            chk("halt_halted", {63'd0, halted}, 64'd1);
            chk("halt_no_req", {62'd0, ifu_req_valid, lsu_req_valid}, 64'd0);
            chk("halt_no_commit", {63'd0, commit}, 64'd0);
        end
        chk("halt_pc", {32'd0, pc}, {32'd0, 32'h8000_0004});
`ifdef NPC_SEQ_PERF_EN
        chk("perf_cycle_frozen", perf_cycle, cyc_snap);
        chk("perf_instret", perf_instret, 64'd2);
`else
        chk("perf_cycle_tied", perf_cycle, 64'd0);
        chk("perf_instret_tied", perf_instret, 64'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
